// File: rtl/weight_load_scheduler.sv
// Buffers host weight/bias configuration writes in a FIFO and issues them on a single
// valid/ready write port, generating the within-neuron weight address automatically.
module weight_load_scheduler #(
    parameter int unsigned NUM_LAYERS  = 4,
    parameter int unsigned MAX_NEURONS = 32,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_soft_rst,
    input  logic [31:0]                      i_cfg_layer,
    input  logic [31:0]                      i_cfg_neuron,
    input  logic                             i_cfg_weight_valid,
    input  logic                             i_cfg_bias_valid,
    input  logic [DATA_WIDTH-1:0]            i_cfg_weight,
    input  logic [DATA_WIDTH-1:0]            i_cfg_bias,
    input  logic [NUM_LAYERS*ADDR_WIDTH-1:0] i_layer_fan_in,
    output logic                             o_wr_en,
    input  logic                             i_wr_ready,
    output logic                             o_wr_is_bias,
    output logic [7:0]                       o_wr_layer,
    output logic [7:0]                       o_wr_neuron,
    output logic [ADDR_WIDTH-1:0]            o_wr_addr,
    output logic [DATA_WIDTH-1:0]            o_wr_data,
    output logic                             o_busy,
    output logic [$clog2(FIFO_DEPTH):0]      o_fifo_level,
    output logic [2:0]                       o_err_flags
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef struct packed {
        logic                  is_bias;
        logic [7:0]            layer;
        logic [7:0]            neuron;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    typedef enum logic {
        StIdle  = 1'b0,
        StIssue = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Enqueue side
    // ------------------------------------------------------------------
    logic                  w_reset;
    logic                  w_any_strobe;
    logic                  w_in_range;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    entry_t                w_push_entry;
    entry_t                w_head;

    entry_t                r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]      r_count;
    logic [2:0]            r_err;

    assign w_reset      = i_rst | i_soft_rst;
    assign w_any_strobe = i_cfg_weight_valid | i_cfg_bias_valid;
    // Full 32-bit compares also reject any nonzero upper bits.
    assign w_in_range   = (i_cfg_layer < NUM_LAYERS) && (i_cfg_neuron < MAX_NEURONS);
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == LVL_W'(FIFO_DEPTH));
    assign w_push       = w_any_strobe && w_in_range && (!w_full || w_pop);
    assign w_head       = r_mem[r_rd_ptr];

    always_comb begin
        w_push_entry         = '0;
        w_push_entry.is_bias = !i_cfg_weight_valid;
        w_push_entry.layer   = i_cfg_layer[7:0];
        w_push_entry.neuron  = i_cfg_neuron[7:0];
        w_push_entry.data    = i_cfg_weight_valid ? i_cfg_weight : i_cfg_bias;
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LVL_W'(1);
                2'b01:   r_count <= r_count - LVL_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_reset) begin
            r_err <= '0;
        end else begin
            if (w_any_strobe && w_in_range && w_full && !w_pop) begin
                r_err[0] <= 1'b1;
            end
            if (w_any_strobe && !w_in_range) begin
                r_err[1] <= 1'b1;
            end
            if (i_cfg_weight_valid && i_cfg_bias_valid) begin
                r_err[2] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Dispatcher FSM
    // ------------------------------------------------------------------
    state_e r_state;
    state_e w_state_d;

    always_ff @(posedge i_clk) begin
        if (w_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_pop     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_state_d = StIssue;
                end
            end
            StIssue: begin
                if (i_wr_ready) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Address tracker and output register
    // ------------------------------------------------------------------
    logic                  r_track_valid;
    logic [7:0]            r_last_layer;
    logic [7:0]            r_last_neuron;
    logic [ADDR_WIDTH-1:0] r_next_addr;

    logic [ADDR_WIDTH-1:0] w_fan_in;
    logic                  w_track_hit;
    logic [ADDR_WIDTH-1:0] w_load_addr;
    logic [ADDR_WIDTH-1:0] w_addr_inc;
    logic [ADDR_WIDTH-1:0] w_next_addr;

    logic                  r_wr_is_bias;
    logic [7:0]            r_wr_layer;
    logic [7:0]            r_wr_neuron;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;

    always_comb begin
        w_fan_in = '0;
        for (int i = 0; i < int'(NUM_LAYERS); i++) begin
            if (w_head.layer == 8'(i)) begin
                w_fan_in = i_layer_fan_in[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // A fan-in of 0 never matches a nonzero increment, so it wraps at 2^ADDR_WIDTH.
    assign w_track_hit = r_track_valid && (w_head.layer == r_last_layer) &&
                         (w_head.neuron == r_last_neuron);
    assign w_load_addr = (!w_head.is_bias && w_track_hit) ? r_next_addr : '0;
    assign w_addr_inc  = w_load_addr + ADDR_WIDTH'(1);
    assign w_next_addr = (w_addr_inc == w_fan_in) ? '0 : w_addr_inc;

    always_ff @(posedge i_clk) begin
        if (w_reset) begin
            r_track_valid <= 1'b0;
            r_last_layer  <= '0;
            r_last_neuron <= '0;
            r_next_addr   <= '0;
            r_wr_is_bias  <= 1'b0;
            r_wr_layer    <= '0;
            r_wr_neuron   <= '0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
        end else if (w_pop) begin
            r_wr_is_bias <= w_head.is_bias;
            r_wr_layer   <= w_head.layer;
            r_wr_neuron  <= w_head.neuron;
            r_wr_addr    <= w_load_addr;
            r_wr_data    <= w_head.data;
            if (!w_head.is_bias) begin
                r_track_valid <= 1'b1;
                r_last_layer  <= w_head.layer;
                r_last_neuron <= w_head.neuron;
                r_next_addr   <= w_next_addr;
            end
        end
    end

    assign o_wr_en      = (r_state == StIssue);
    assign o_wr_is_bias = r_wr_is_bias;
    assign o_wr_layer   = r_wr_layer;
    assign o_wr_neuron  = r_wr_neuron;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_busy       = !w_empty || o_wr_en;
    assign o_fifo_level = r_count;
    assign o_err_flags  = r_err;

endmodule

// File: tb/tb_weight_load_scheduler.sv
// Self-checking bench for weight_load_scheduler: directed vector table, multi-cycle corner
// sequences, and a randomized run checked against a queue-based reference model.
module tb_weight_load_scheduler;

    localparam int NL = 4;
    localparam int MN = 32;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int FD = 8;

    logic              clk = 1'b0;
    logic              rst, soft_rst, wv, bv, rdy;
    logic [31:0]       lay, neu;
    logic [DW-1:0]     wd, bd;
    logic [NL*AW-1:0]  fan;
    logic              o_wr_en, o_wr_is_bias, o_busy;
    logic [7:0]        o_wr_layer, o_wr_neuron;
    logic [AW-1:0]     o_wr_addr;
    logic [DW-1:0]     o_wr_data;
    logic [3:0]        o_fifo_level;
    logic [2:0]        o_err_flags;

    always #5 clk = ~clk;

    weight_load_scheduler #(
        .NUM_LAYERS (NL),
        .MAX_NEURONS(MN),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (FD)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_soft_rst        (soft_rst),
        .i_cfg_layer       (lay),
        .i_cfg_neuron      (neu),
        .i_cfg_weight_valid(wv),
        .i_cfg_bias_valid  (bv),
        .i_cfg_weight      (wd),
        .i_cfg_bias        (bd),
        .i_layer_fan_in    (fan),
        .o_wr_en           (o_wr_en),
        .i_wr_ready        (rdy),
        .o_wr_is_bias      (o_wr_is_bias),
        .o_wr_layer        (o_wr_layer),
        .o_wr_neuron       (o_wr_neuron),
        .o_wr_addr         (o_wr_addr),
        .o_wr_data         (o_wr_data),
        .o_busy            (o_busy),
        .o_fifo_level      (o_fifo_level),
        .o_err_flags       (o_err_flags)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit mdl_on  = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [67:0] pack(input logic en, input logic b, input logic [7:0] l,
                                         input logic [7:0] n, input logic [AW-1:0] a,
                                         input logic [DW-1:0] d, input logic busy,
                                         input logic [3:0] lvl, input logic [2:0] e);
        return {en, b, l, n, a, d, busy, lvl, e};
    endfunction

    function automatic logic [67:0] act_full();
        return pack(o_wr_en, o_wr_is_bias, o_wr_layer, o_wr_neuron, o_wr_addr, o_wr_data,
                    o_busy, o_fifo_level, o_err_flags);
    endfunction

    // ---------------- reference model: pending queue + one output slot ----------------
    typedef struct packed {
        logic          is_bias;
        logic [7:0]    layer;
        logic [7:0]    neuron;
        logic [DW-1:0] data;
    } ent_t;

    ent_t       mq[$];
    ent_t       m_out;
    logic       m_en;
    int         m_addr;
    logic [2:0] m_err;
    bit         m_tv;
    int         m_ll, m_ln, m_na;

    function automatic int fan_eff(input int l);
        int f;
        f = int'(fan[l*AW +: AW]);
        return (f == 0) ? (1 << AW) : f;
    endfunction

    task automatic model_step();
        bit   pop, have_push;
        ent_t ne;
        if (rst || soft_rst) begin
            mq.delete();
            m_en = 1'b0; m_out = '0; m_addr = 0; m_tv = 1'b0; m_err = '0;
            return;
        end
        pop       = (mq.size() != 0) && (!m_en || rdy);
        have_push = 1'b0;
        ne        = '0;
        if (wv || bv) begin
            if (wv && bv) m_err[2] = 1'b1;
            if (lay >= NL || neu >= MN) m_err[1] = 1'b1;
            else if (mq.size() >= FD && !pop) m_err[0] = 1'b1;
            else begin
                have_push  = 1'b1;
                ne.is_bias = !wv;
                ne.layer   = lay[7:0];
                ne.neuron  = neu[7:0];
                ne.data    = wv ? wd : bd;
            end
        end
        if (pop) begin
            m_out  = mq.pop_front();
            m_en   = 1'b1;
            m_addr = 0;
            if (!m_out.is_bias) begin
                if (m_tv && m_ll == int'(m_out.layer) && m_ln == int'(m_out.neuron)) begin
                    m_addr = m_na;
                end else begin
                    m_tv = 1'b1; m_ll = int'(m_out.layer); m_ln = int'(m_out.neuron);
                end
                m_na = (m_addr + 1 == fan_eff(int'(m_out.layer))) ? 0 : (m_addr + 1) % (1 << AW);
            end
        end else if (m_en && rdy) begin
            m_en = 1'b0;
        end
        if (have_push) mq.push_back(ne);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Payload is only meaningful while wr_en is high.
    initial forever begin
        @(negedge clk);
        if (mdl_on) begin
            chk("model",
                pack(o_wr_en, o_wr_en & o_wr_is_bias, o_wr_en ? o_wr_layer : 8'h0,
                     o_wr_en ? o_wr_neuron : 8'h0, o_wr_en ? o_wr_addr : '0,
                     o_wr_en ? o_wr_data : '0, o_busy, o_fifo_level, o_err_flags),
                pack(m_en, m_en & m_out.is_bias, m_en ? m_out.layer : 8'h0,
                     m_en ? m_out.neuron : 8'h0, m_en ? AW'(m_addr) : '0,
                     m_en ? m_out.data : '0, (mq.size() != 0) || m_en, 4'(mq.size()), m_err));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit w, input bit b, input logic [31:0] l, input logic [31:0] n,
                         input logic [DW-1:0] d);
        wv = w; bv = b; lay = l; neu = n;
        wd = w ? d : ~d;
        bd = (b && !w) ? d : ~d;
        if (!w && !b) begin
            wd = '0; bd = '0;
        end
    endtask

    task automatic do_soft_rst(input string name);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        soft_rst = 1'b1;
        next_cycle();
        soft_rst = 1'b0;
        @(negedge clk);
        chk(name, act_full(), '0);
    endtask

    typedef struct {
        bit        wv, bv;
        int        l, n, d;
        bit        e_en, e_bias;
        int        e_l, e_n, e_a, e_d;
    } vec_t;

    function automatic vec_t mk(input bit w, input bit b, input int l, input int n, input int d,
                                input bit een, input bit eb, input int el, input int enn,
                                input int ea, input int ed);
        vec_t v;
        v.wv = w; v.bv = b; v.l = l; v.n = n; v.d = d;
        v.e_en = een; v.e_bias = eb; v.e_l = el; v.e_n = enn; v.e_a = ea; v.e_d = ed;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        int got;
        int wait_cnt;
        // Layer fan-ins: L0 = 16, L1 = 4, L2 = 0 (full range), L3 = 3.
        fan = {10'd3, 10'd0, 10'd4, 10'd16};
        rst = 1'b1; soft_rst = 1'b0; rdy = 1'b1;
        drive(0, 0, 0, 0, 0);

        // Layer 1 / neuron 3, fan-in 4: addresses wrap after 3.
        vecs.push_back(mk(1, 0, 1, 3, 'h100, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 3, 'h101, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 3, 'h102, 1, 0, 1, 3, 0, 'h100));
        vecs.push_back(mk(1, 0, 1, 3, 'h103, 1, 0, 1, 3, 1, 'h101));
        vecs.push_back(mk(1, 0, 1, 3, 'h104, 1, 0, 1, 3, 2, 'h102));
        vecs.push_back(mk(1, 0, 1, 3, 'h105, 1, 0, 1, 3, 3, 'h103));
        vecs.push_back(mk(0, 0, 0, 0, 0,     1, 0, 1, 3, 0, 'h104));
        vecs.push_back(mk(0, 0, 0, 0, 0,     1, 0, 1, 3, 1, 'h105));
        vecs.push_back(mk(0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0));
        // Interleaved weights/bias with re-targeting.
        vecs.push_back(mk(1, 0, 0, 0, 'h200, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 'h201, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 'h202, 1, 0, 0, 0, 0, 'h200));
        vecs.push_back(mk(0, 1, 0, 0, 'h203, 1, 0, 0, 0, 1, 'h201));
        vecs.push_back(mk(1, 0, 0, 1, 'h204, 1, 0, 0, 0, 2, 'h202));
        vecs.push_back(mk(1, 0, 0, 1, 'h205, 1, 1, 0, 0, 0, 'h203));
        vecs.push_back(mk(1, 0, 0, 0, 'h206, 1, 0, 0, 1, 0, 'h204));
        vecs.push_back(mk(0, 0, 0, 0, 0,     1, 0, 0, 1, 1, 'h205));
        vecs.push_back(mk(0, 0, 0, 0, 0,     1, 0, 0, 0, 0, 'h206));
        vecs.push_back(mk(0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0));

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", act_full(), '0);
        rst    = 1'b0;
        mdl_on = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            next_cycle();
            rdy = 1'b1;
            drive(vecs[i].wv, vecs[i].bv, vecs[i].l, vecs[i].n, vecs[i].d);
            @(negedge clk);
            chk($sformatf("tbl%0d_en", i), o_wr_en, vecs[i].e_en);
            if (vecs[i].e_en) begin
                chk($sformatf("tbl%0d_payload", i),
                    {o_wr_is_bias, o_wr_layer, o_wr_neuron, o_wr_addr, o_wr_data},
                    {vecs[i].e_bias, 8'(vecs[i].e_l), 8'(vecs[i].e_n), AW'(vecs[i].e_a),
                     DW'(vecs[i].e_d)});
            end
        end

        // Back-pressure: 10 weights while stalled; one is held at the port, 8 fill the FIFO.
        for (int k = 0; k < 20; k++) begin
            next_cycle();
            rdy = 1'b0;
            if (k < 10) drive(1, 0, 2, 5, 'h300 + k);
            else        drive(0, 0, 0, 0, 0);
            @(negedge clk);
            if (k == 2 || k == 11 || k == 19) begin
                chk($sformatf("bp_hold%0d", k),
                    {o_wr_en, o_wr_is_bias, o_wr_layer, o_wr_neuron, o_wr_addr, o_wr_data},
                    {1'b1, 1'b0, 8'd2, 8'd5, 10'd0, 32'h300});
            end
        end
        chk("bp_level", o_fifo_level, 4'd8);
        chk("bp_ovf_flag", o_err_flags, 3'b001);
        got = 0;
        for (int k = 0; k < 30; k++) begin
            next_cycle();
            rdy = 1'b1;
            @(negedge clk);
            if (o_wr_en) begin
                chk($sformatf("bp_addr%0d", got), o_wr_addr, AW'(got));
                chk($sformatf("bp_data%0d", got), o_wr_data, 32'h300 + got);
                got++;
            end
        end
        chk("bp_write_count", got, 9);

        do_soft_rst("soft_rst_clears");

        // Illegal targets: layer 4, neuron 32, upper bits in layer and neuron.
        for (int k = 0; k < 7; k++) begin
            next_cycle();
            case (k)
                0:       drive(1, 0, 4, 0, 'h11);
                1:       drive(1, 0, 0, 32, 'h12);
                2:       drive(0, 1, 32'h100, 0, 'h13);
                3:       drive(1, 0, 0, 32'h0100_0000, 'h14);
                default: drive(0, 0, 0, 0, 0);
            endcase
            @(negedge clk);
            chk($sformatf("illegal%0d_idle", k), {o_wr_en, o_fifo_level}, '0);
        end
        chk("illegal_flags", o_err_flags, 3'b010);

        do_soft_rst("soft_rst_clears2");

        // Collision: weight wins, bias dropped.
        next_cycle();
        drive(1, 1, 1, 2, 0);
        wd = 32'h55; bd = 32'hAA;
        @(negedge clk);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        next_cycle();
        @(negedge clk);
        chk("coll_write", act_full(),
            pack(1'b1, 1'b0, 8'd1, 8'd2, '0, 32'h55, 1'b1, 4'd0, 3'b100));
        next_cycle();
        @(negedge clk);
        chk("coll_single", {o_wr_en, o_fifo_level}, '0);

        do_soft_rst("soft_rst_clears3");

        // Soft reset while a write is stalled: it must vanish.
        next_cycle();
        rdy = 1'b0;
        drive(1, 0, 3, 1, 'h77);
        @(negedge clk);
        wait_cnt = 0;
        while (!o_wr_en && wait_cnt < 10) begin
            next_cycle();
            drive(0, 0, 0, 0, 0);
            @(negedge clk);
            wait_cnt++;
        end
        chk("midrst_en_seen", o_wr_en, 1'b1);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        soft_rst = 1'b1;
        next_cycle();
        soft_rst = 1'b0;
        rdy      = 1'b1;
        @(negedge clk);
        chk("midrst_drop", act_full(), '0);
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            @(negedge clk);
            chk($sformatf("midrst_quiet%0d", k), o_wr_en, 1'b0);
        end

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            int r1, r2;
            logic [31:0] l, n;
            next_cycle();
            r1 = $urandom_range(0, 19);
            r2 = $urandom_range(0, 19);
            l  = (r1 < 18) ? 32'(r1 % 4) : ((r1 == 18) ? 32'd4 : 32'h100);
            n  = (r2 < 18) ? 32'(r2 % 3) : ((r2 == 18) ? 32'd32 : 32'h0100_0001);
            wv = ($urandom_range(0, 99) < 40);
            bv = ($urandom_range(0, 99) < 15);
            lay = l; neu = n;
            wd = $urandom; bd = $urandom;
            rdy = (c < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            soft_rst = ($urandom_range(0, 299) == 0);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0);
        soft_rst = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
